// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared constants and types for the 19-bit pipelined CPU front end
//            (data width, NOP encoding, redirect encodings, fetch FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Architectural word width: instructions, PCs and data.
  localparam int XLEN = 19;

  // All-zero instruction word is the pipeline NOP / bubble.
  localparam logic [XLEN-1:0] NOP = '0;

  // Redirect request encodings on jumpE (2'b11 behaves like JUMP_J).
  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_RET  = 2'b10;

  // Fetch FSM: FETCH issues requests, DRAIN swallows one stale response.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Small prefetch FIFO holding {instruction, pc} pairs between the
//            instruction-memory response and the IF/ID register. Supports a
//            synchronous clear that wins over push and pop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * cpu_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full queue is only accepted when the head leaves the same cycle.
  assign w_do_push = i_push && !i_clr && (!o_full || i_pop);
  assign w_do_pop  = i_pop  && !i_clr && !o_empty;

  // Storage array: written only, never reset (pointers define what is live).
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_cycle.sv
`default_nettype none
// ============================================================================
// Module   : fetch_cycle
// Brief    : Instruction-fetch stage. Owns the PC, the request/grant handshake
//            to instruction memory, a prefetch queue and the IF/ID register.
//            Handles decode stall, flush and jump/return redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_cycle
  import cpu_pkg::*;
#(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter int              PC_INC   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallD,
  input  logic            flushD,
  input  logic [1:0]      jumpE,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] stack_data,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcplus4D,
  output logic            validD
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tag_pc;
  logic            r_out;

  logic [XLEN-1:0] r_instrD;
  logic [XLEN-1:0] r_pcD;
  logic [XLEN-1:0] r_pcplus4D;
  logic            r_validD;

  logic            w_redirect;
  logic            w_kill;
  logic [XLEN-1:0] w_target;
  logic [CW:0]     w_inflight;
  logic            w_fire;
  logic            w_out_nxt;
  logic            w_push;
  logic            w_load;
  logic            w_pop;
  logic [2*XLEN-1:0] w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;

  assign w_redirect = (jumpE != JUMP_NONE);
  assign w_kill     = w_redirect || flushD;
  assign w_target   = (jumpE == JUMP_RET) ? stack_data : jump_target;

  // Queue entries plus the outstanding response must stay within the queue depth.
  assign w_inflight = {1'b0, w_count} + {{CW{1'b0}}, r_out};
  assign imem_req   = !rst && (r_state == ST_FETCH) && (w_inflight < (CW+1)'(QDEPTH));
  assign imem_addr  = r_pc;
  assign w_fire     = imem_req && imem_gnt;

  // A response is still owed after this cycle if we grant now, or if the
  // previous one has not shown up yet.
  assign w_out_nxt  = w_fire || (r_out && !imem_rvalid);

  // Only responses that belong to the current fetch stream are queued.
  assign w_push = imem_rvalid && r_out && (r_state == ST_FETCH) && !w_kill;

  // IF/ID advances when decode takes it or it is empty; redirects/flushes win.
  assign w_load = !w_kill && (!stallD || !r_validD);
  assign w_pop  = w_load && !w_empty;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (2*XLEN)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_kill),
    .i_push      (w_push),
    .i_push_data ({imem_rdata, r_tag_pc}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Next-state logic: killed stream with a response still owed goes to DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH: if (w_kill && w_out_nxt) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!w_out_nxt)          w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, response tag and outstanding flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_tag_pc <= '0;
      r_out    <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      if (w_fire) begin
        r_tag_pc <= r_pc;
      end
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (w_fire) begin
        r_pc <= r_pc + XLEN'(PC_INC);
      end
    end
  end

  // IF/ID register; pcplus4D is captured at load time, not derived on the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instrD   <= NOP;
      r_pcD      <= '0;
      r_pcplus4D <= '0;
      r_validD   <= 1'b0;
    end else if (w_kill) begin
      r_instrD <= NOP;
      r_validD <= 1'b0;
    end else if (w_load) begin
      if (!w_empty) begin
        r_instrD   <= w_head[2*XLEN-1:XLEN];
        r_pcD      <= w_head[XLEN-1:0];
        r_pcplus4D <= w_head[XLEN-1:0] + XLEN'(PC_INC);
        r_validD   <= 1'b1;
      end else begin
        r_validD   <= 1'b0;
      end
    end
  end

  assign instrD   = r_instrD;
  assign pcD      = r_pcD;
  assign pcplus4D = r_pcplus4D;
  assign validD   = r_validD;

  // Credit accounting must never let a response arrive at a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full && !w_pop));

endmodule : fetch_cycle
`default_nettype wire

// File: tb/tb_fetch_cycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_cycle
// Brief    : Self-checking bench for fetch_cycle. A memory model answers every
//            grant one cycle later with addr^1; a scoreboard of issued, still
//            live PCs predicts every instruction that reaches decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_cycle;
  import cpu_pkg::*;

  localparam int          QD     = 4;
  localparam logic [18:0] RST_PC = 19'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD, flushD;
  logic [1:0]  jumpE;
  logic [18:0] jump_target, stack_data;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [18:0] imem_addr, imem_rdata;
  logic [18:0] instrD, pcD, pcplus4D;
  logic        validD;

  fetch_cycle #(
    .XLEN(19), .PC_INC(4), .RESET_PC(RST_PC), .QDEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .jumpE(jumpE),
    .jump_target(jump_target), .stack_data(stack_data),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: live issued PCs in program order, and the next fetch PC.
  logic [18:0] sb[$];
  logic [18:0] m_pc;
  logic        p_valid;
  logic [18:0] p_pc, p_instr, p_pc4;

  function automatic logic [18:0] mem_word(input logic [18:0] a);
    return a ^ 19'h00001;
  endfunction

  // One clock: check issue, update the model, advance, answer memory, check IF/ID.
  task automatic tick();
    logic        fire, redir, kill, hold;
    logic [18:0] a, tgt, exp_pc;
    #2;
    fire  = imem_req && imem_gnt;
    a     = imem_addr;
    redir = (jumpE != 2'b00);
    kill  = redir || flushD;
    hold  = stallD && p_valid && !kill;
    tgt   = (jumpE == 2'b10) ? stack_data : jump_target;
    n_tests++;
    if (imem_req && sb.size() >= QD) begin
      n_fail++;
      $display("FAIL credit: imem_req=1 with %0d live fetches, limit %0d", sb.size(), QD);
    end
    if (fire) begin
      n_tests++;
      if (a !== m_pc) begin
        n_fail++;
        $display("FAIL issue_addr: imem_addr=%h expected %h", a, m_pc);
      end
    end
    if (kill) sb.delete();
    else if (fire) sb.push_back(a);
    if (redir) m_pc = tgt;
    else if (fire) m_pc = m_pc + 19'd4;
    @(posedge clk); #1;
    imem_rvalid = fire;
    imem_rdata  = fire ? mem_word(a) : 19'($urandom);
    n_tests++;
    if (kill) begin
      if (validD !== 1'b0 || (redir && instrD !== 19'd0)) begin
        n_fail++;
        $display("FAIL kill: validD=%b instrD=%h expected validD=0%s", validD, instrD,
                 redir ? " instrD=0" : "");
      end
    end else if (hold) begin
      if ({validD, pcD, instrD, pcplus4D} !== {1'b1, p_pc, p_instr, p_pc4}) begin
        n_fail++;
        $display("FAIL hold: v=%b pc=%h ins=%h pc4=%h expected v=1 pc=%h ins=%h pc4=%h",
                 validD, pcD, instrD, pcplus4D, p_pc, p_instr, p_pc4);
      end
    end else if (validD === 1'b1) begin
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL stream: validD=1 pcD=%h but no live fetch expected", pcD);
      end else begin
        exp_pc = sb.pop_front();
        if (pcD !== exp_pc || instrD !== mem_word(exp_pc) || pcplus4D !== exp_pc + 19'd4) begin
          n_fail++;
          $display("FAIL stream: pc=%h ins=%h pc4=%h expected pc=%h ins=%h pc4=%h",
                   pcD, instrD, pcplus4D, exp_pc, mem_word(exp_pc), exp_pc + 19'd4);
        end
      end
    end else if (validD !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_x: validD=%b expected 0 or 1", validD);
    end
    p_valid = validD; p_pc = pcD; p_instr = instrD; p_pc4 = pcplus4D;
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc = RST_PC;
    p_valid = 1'b0; p_pc = '0; p_instr = '0; p_pc4 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stallD = 0; flushD = 0; jumpE = 2'b00;
    jump_target = '0; stack_data = '0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    @(posedge clk); #1; @(posedge clk); #1;
    n_tests++;
    if ({validD, imem_req, instrD, pcD, pcplus4D} !== 59'd0) begin
      n_fail++;
      $display("FAIL reset: v=%b req=%b ins=%h pc=%h pc4=%h expected all zero",
               validD, imem_req, instrD, pcD, pcplus4D);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // Fixed latency (valid in cycle 3) then back-to-back PCs 4, 8.
  task automatic test_stream();
    imem_gnt = 1'b1;
    tick(); tick();
    n_tests++;
    if (validD !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: validD=%b after 2 cycles expected 0", validD);
    end
    tick();
    n_tests++;
    if ({validD, pcD, instrD, pcplus4D} !== {1'b1, 19'd0, 19'h00001, 19'd4}) begin
      n_fail++;
      $display("FAIL latency_first: v=%b pc=%h ins=%h pc4=%h expected v=1 pc=0 ins=1 pc4=4",
               validD, pcD, instrD, pcplus4D);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_tests++;
      if (validD !== 1'b1 || pcD !== 19'(4*i)) begin
        n_fail++;
        $display("FAIL back_to_back: v=%b pc=%h expected v=1 pc=%h", validD, pcD, 19'(4*i));
      end
    end
  endtask

  // Five stalled cycles on pcD=8, credit throttling, then lossless resume.
  task automatic test_stall();
    stallD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (validD !== 1'b1 || pcD !== 19'd8) begin
        n_fail++;
        $display("FAIL stall_hold: v=%b pc=%h expected v=1 pc=8", validD, pcD);
      end
    end
    #2;
    n_tests++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_credit: imem_req=%b with full queue expected 0", imem_req);
    end
    stallD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (validD !== 1'b1 || pcD !== 19'(12 + 4*i)) begin
        n_fail++;
        $display("FAIL stall_resume: v=%b pc=%h expected v=1 pc=%h", validD, pcD, 19'(12 + 4*i));
      end
    end
  endtask

  // Run until validD (bounded); report the first pcD seen against the expectation.
  task automatic wait_first(input string name, input logic [18:0] exp_pc);
    bit found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (validD === 1'b1) found = 1;
    end
    n_tests++;
    if (!found || pcD !== exp_pc) begin
      n_fail++;
      $display("FAIL %s: found=%0d pcD=%h expected valid pcD=%h", name, found, pcD, exp_pc);
    end
  endtask

  task automatic test_jump();
    imem_gnt = 1'b1; stallD = 1'b0;
    jumpE = 2'b01; jump_target = 19'h00100;
    tick();
    jumpE = 2'b00;
    wait_first("jump_target", 19'h00100);
  endtask

  task automatic test_return_stall();
    stallD = 1'b1; jumpE = 2'b10; stack_data = 19'h00040; jump_target = 19'h12344;
    tick();
    jumpE = 2'b00; stallD = 1'b0;
    wait_first("return_over_stall", 19'h00040);
  endtask

  task automatic test_wrap();
    jumpE = 2'b01; jump_target = 19'h7FFF8;
    tick();
    jumpE = 2'b00;
    wait_first("wrap_first", 19'h7FFF8);
    for (int i = 1; i < 4; i++) begin
      tick();
      n_tests++;
      if (validD !== 1'b1 || pcD !== 19'(19'h7FFF8 + 19'(4*i))) begin
        n_fail++;
        $display("FAIL wrap_seq: v=%b pc=%h expected v=1 pc=%h", validD, pcD,
                 19'(19'h7FFF8 + 19'(4*i)));
      end
    end
  endtask

  // Asynchronous reset while the queue holds several entries.
  task automatic test_reset_mid();
    stallD = 1'b1;
    tick(); tick(); tick();
    #2;
    rst = 1'b1; imem_rvalid = 1'b0;
    #1;
    n_tests++;
    if (validD !== 1'b0 || imem_req !== 1'b0 || instrD !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_async: v=%b req=%b ins=%h expected 0 0 0", validD, imem_req, instrD);
    end
    @(posedge clk); #1;
    rst = 1'b0; stallD = 1'b0;
    model_reset();
    wait_first("reset_restart", RST_PC);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      imem_gnt    = ($urandom_range(0, 9) < 7);
      stallD      = ($urandom_range(0, 9) < 3);
      flushD      = ($urandom_range(0, 19) == 0);
      jumpE       = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      jump_target = 19'($urandom);
      stack_data  = 19'($urandom);
      tick();
    end
    flushD = 1'b0; jumpE = 2'b00; stallD = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_return_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fetch_cycle
`default_nettype wire

// File: doc/fetch_cycle.md
Name: fetch_cycle

Overview:
Instruction-fetch stage of the 19-bit pipelined CPU. It produces the IF/ID interface that the decode stage consumes: instrD, pcD, pcplus4D and a valid flag. The block owns the PC register, a request/grant handshake to instruction memory, and a small prefetch queue. It accepts decode-stage stall, flush, and jump/return redirects; a return takes its target from the call-stack read data.

Parameters:
XLEN, 19, instruction, PC and data width
PC_INC, 4, PC increment per sequential instruction (pcplus4 = pc + PC_INC)
RESET_PC, 19'd0, PC value loaded at reset
QDEPTH, 4, prefetch queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stallD  in  1  decode not accepting; hold IF/ID outputs
flushD  in  1  invalidate IF/ID and prefetch queue (no PC change)
jumpE  in  2  redirect: 00 none, 01 jump to jump_target, 10 return to stack_data, 11 treated as 01
jump_target  in  19  jump/branch target
stack_data  in  19  return address from the call stack
imem_req  out  1  fetch request
imem_addr  out  19  fetch address (current PC)
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid; exactly 1 cycle after a grant
imem_rdata  in  19  instruction word
instrD  out  19  instruction to decode
pcD  out  19  PC of instrD
pcplus4D  out  19  pcD + PC_INC
validD  out  1  IF/ID holds a live instruction

Behaviour:
- Reset (async, rst=1): pc=RESET_PC; queue empty; outstanding=0; state=FETCH; imem_req=0; instrD=0 (NOP), pcD=0, pcplus4D=0, validD=0. Reset mid-operation discards queue contents and in-flight data.
- Issue: in FETCH, imem_req=1 when count+outstanding < QDEPTH. imem_addr=pc. On req&gnt: pc <= pc+PC_INC (mod 2^19, wraps 0x7FFFC->0x00000 for PC_INC=4), outstanding=1, and the issued PC is tagged for the response.
- Response: on imem_rvalid with a live tag, push {imem_rdata, tagged PC} into the queue. Credit accounting guarantees this never overflows; an overflow is a design error (assertion).
- IF/ID register: when !stallD or !validD, load from the queue head and pop if the queue is non-empty, else set validD=0. When stallD&validD, hold all outputs. A push and a pop in the same cycle is legal; count is unchanged.
- Latency: a grant in cycle N gives rvalid in N+1, a queue write at the end of N+1, and instrD valid in cycle N+3 when not stalled.
- Redirect (jumpE!=0): highest priority, overriding stallD and the IF/ID load.
  - pc <= jump_target (01/11) or stack_data (10).
  - Queue cleared; validD <= 0; instrD <= 0.
  - If a response is outstanding or granted this cycle, the state goes to DRAIN.
- flushD alone: clears the queue and validD and drops any in-flight response (DRAIN if outstanding); pc is unchanged.
- FSM:
  - FETCH: normal operation.
  - DRAIN: imem_req=0; the next imem_rvalid is discarded; then return to FETCH. DRAIN lasts exactly 1 cycle given fixed latency.
- Redirect together with flushD: act as redirect.
- Redirect during DRAIN: update pc and remain in DRAIN until the pending response is dropped.
- pcplus4D is computed when the IF/ID register loads, not combinationally on the output.

Decomposition:
- Shared package (cpu_pkg): XLEN, the NOP encoding (19'd0), jump encodings (JUMP_NONE=2'b00, JUMP_J=2'b01, JUMP_RET=2'b10), and the fetch FSM state enum.
- One sub-module: fetch_queue (QDEPTH x 38-bit FIFO with clear, push, pop, count, full/empty).
- The top level holds the PC, credit/outstanding logic, FSM and IF/ID register.

Test Plan:
- Reset then imem_gnt=1 with memory word = address^0x1: cycle 3 gives instrD=0x00001, pcD=0, pcplus4D=4, validD=1; PCs then stream 4, 8, 12 with no bubbles.
- stallD=1 for 5 cycles after pcD=8: outputs hold pcD=8; imem_req drops once 4 entries are queued/outstanding; after release, pcD=12, 16, ... with no loss or duplication.
- jumpE=01, jump_target=0x00100 while a response is in flight: next cycle validD=0; the stale word is dropped; the first new instrD has pcD=0x00100.
- jumpE=10, stack_data=0x00040, asserted together with stallD=1: redirect wins; the queue is cleared; the next valid pcD=0x00040.
- Start pc near wrap (RESET_PC=19'h7FFF8): pcD sequence 7FFF8, 7FFFC, 00000, 00004.
- Assert rst for 1 cycle mid-stream with 3 entries queued: validD, imem_req and the queue clear immediately (async); fetch restarts at RESET_PC.
